// File: rtl/hazard_stall_unit.sv
// Hazard detection for a 5-stage MIPS pipeline: detects load-use and ID-stage branch
// operand hazards from a shadow of the EX/MEM destinations and stalls PC and IF/ID.
module hazard_stall_unit #(
    parameter int CNT_W        = 16,
    parameter bit BRANCH_IN_ID = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      Inst,
    input  logic             ID_valid,
    input  logic             Flush,
    output logic             Pipe_stall,
    output logic             PC_write,
    output logic             IFID_write,
    output logic [CNT_W-1:0] Stall_count
);

    typedef struct packed {
        logic       wr;
        logic [4:0] dst;
        logic       ld;
    } slot_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    slot_t            r_ex;
    slot_t            r_mem;
    logic [CNT_W-1:0] r_cnt;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_use_rs;
    logic       w_use_rt;
    logic       w_is_br;
    slot_t      w_id_slot;
    logic       w_ex_hit;
    logic       w_mem_hit;
    logic       w_stall;
    logic       w_unused;

    assign w_op     = Inst[31:26];
    assign w_rs     = Inst[25:21];
    assign w_rt     = Inst[20:16];
    assign w_rd     = Inst[15:11];
    assign w_unused = ^Inst[10:0];

    always_comb begin
        w_use_rs      = 1'b0;
        w_use_rt      = 1'b0;
        w_is_br       = 1'b0;
        w_id_slot     = '0;
        unique case (w_op)
            OP_RTYPE: begin
                w_use_rs      = 1'b1;
                w_use_rt      = 1'b1;
                w_id_slot.dst = w_rd;
            end
            OP_ADDI, OP_ORI: begin
                w_use_rs      = 1'b1;
                w_id_slot.dst = w_rt;
            end
            OP_LW: begin
                w_use_rs      = 1'b1;
                w_id_slot.dst = w_rt;
                w_id_slot.ld  = 1'b1;
            end
            OP_SW: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_is_br  = 1'b1;
            end
            default: ;
        endcase
        // $0 is never a real destination, so a write to it is dropped entirely.
        w_id_slot.wr = (w_id_slot.dst != 5'd0);
        if (!w_id_slot.wr) w_id_slot.ld = 1'b0;
    end

    // Slots only hold wr=1 with a nonzero dst, so a $0 source can never match.
    assign w_ex_hit  = r_ex.wr  && ((w_use_rs && (w_rs == r_ex.dst))  || (w_use_rt && (w_rt == r_ex.dst)));
    assign w_mem_hit = r_mem.wr && ((w_use_rs && (w_rs == r_mem.dst)) || (w_use_rt && (w_rt == r_mem.dst)));

    always_comb begin
        w_stall = 1'b0;
        if (rst_n && ID_valid && !Flush) begin
            if (w_ex_hit && r_ex.ld) w_stall = 1'b1;
            if (BRANCH_IN_ID && w_is_br && (w_ex_hit || (w_mem_hit && r_mem.ld))) w_stall = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_cnt <= '0;
        end else begin
            r_mem <= r_ex;
            if (ID_valid && !Flush && !w_stall) r_ex <= w_id_slot;
            else                                r_ex <= '0;
            if (w_stall && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign Pipe_stall  = w_stall;
    assign PC_write    = ~w_stall;
    assign IFID_write  = ~w_stall;
    assign Stall_count = r_cnt;

endmodule
